// File: rtl/b_port_peer_pkg.sv
// ============================================================================
// Module   : b_port_peer_pkg
// Purpose  : Shared definitions for the moduleB peer: default port widths,
//            FSM state encoding and sideband bit positions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package b_port_peer_pkg;

    // Default widths, used as parameter defaults by b_port_peer.
    localparam int c_data_to_b_width    = 32;
    localparam int c_data_from_b_width  = 32;
    localparam int c_b_extra_in_width   = 4;
    localparam int c_b_extra_out_width  = 4;
    localparam int c_timeout_cycles     = 16;

    // Sideband bit positions.
    localparam int c_strobe_bit    = 0;   // b_extra_in: request strobe
    localparam int c_rsp_valid_bit = 0;   // b_extra_out: response valid

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Counter width able to hold the value `limit` itself.
    function automatic int timer_width(input int limit);
        return $clog2(limit + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/b_port_timer.sv
// ============================================================================
// Module   : b_port_timer
// Purpose  : Saturating cycle counter for the moduleB response timeout.
//            clear loads 1 (the first counted cycle), enable adds 1 per
//            cycle and sticks at the counter maximum; expired is raised
//            once the count reaches LIMIT.
// Ports    : clk, rst    - clock / synchronous active-high reset
//            clear       - load count with 1 (has priority over enable)
//            enable      - increment count
//            expired     - count >= LIMIT
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module b_port_timer
    import b_port_peer_pkg::*;
#(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int c_width = timer_width(LIMIT);
    localparam logic [c_width-1:0] c_max   = '1;
    localparam logic [c_width-1:0] c_limit = c_width'(LIMIT);
    localparam logic [c_width-1:0] c_one   = c_width'(1);

    logic [c_width-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= c_one;
        end else if (enable && (r_count != c_max)) begin
            r_count <= r_count + c_one;
        end
    end

    assign expired = (r_count >= c_limit);

endmodule

`default_nettype wire

// File: rtl/b_port_peer.sv
// ============================================================================
// Module   : b_port_peer
// Purpose  : Peer of moduleB's port set. Turns one upstream valid/ready
//            request into a single strobed transaction on data_to_B /
//            b_extra_in, waits for b_extra_out[0], and returns the captured
//            response on a valid/ready channel. One transaction in flight.
// Ports    : clk, rst                          - clock / sync active-high reset
//            req_valid, req_ready, req_data    - upstream request
//            rsp_valid, rsp_ready, rsp_data,
//            rsp_status, rsp_err               - downstream response
//            data_to_B, b_extra_in             - toward moduleB
//            data_from_B, b_extra_out          - from moduleB
// Config   : B_PORT_PEER_TIMEOUT_EN - when defined, a response that has not
//            arrived within TIMEOUT_CYCLES cycles of ISSUE+WAIT completes
//            with rsp_err=1 and zeroed data/status. When undefined there is
//            no timer and rsp_err is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module b_port_peer
    import b_port_peer_pkg::*;
#(
    parameter int DATA_TO_B_BITWIDTH   = c_data_to_b_width,
    parameter int DATA_FROM_B_BITWIDTH = c_data_from_b_width,
    parameter int B_EXTRA_IN_BITWIDTH  = c_b_extra_in_width,
    parameter int B_EXTRA_OUT_BITWIDTH = c_b_extra_out_width,
    parameter int TIMEOUT_CYCLES       = c_timeout_cycles
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [DATA_TO_B_BITWIDTH-1:0]   req_data,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic [DATA_FROM_B_BITWIDTH-1:0] rsp_data,
    output logic [B_EXTRA_OUT_BITWIDTH-1:0] rsp_status,
    output logic                            rsp_err,
    output logic [DATA_TO_B_BITWIDTH-1:0]   data_to_B,
    input  logic [DATA_FROM_B_BITWIDTH-1:0] data_from_B,
    output logic [B_EXTRA_IN_BITWIDTH-1:0]  b_extra_in,
    input  logic [B_EXTRA_OUT_BITWIDTH-1:0] b_extra_out
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("b_port_peer: TIMEOUT_CYCLES must be >= 2");
    end

    state_t                          r_state;
    state_t                          w_next_state;
    logic [DATA_TO_B_BITWIDTH-1:0]   r_data_to_b;
    logic                            r_strobe;
    logic                            r_rsp_valid;
    logic [DATA_FROM_B_BITWIDTH-1:0] r_rsp_data;
    logic [B_EXTRA_OUT_BITWIDTH-1:0] r_rsp_status;
    logic                            r_rsp_err;

    logic w_req_fire;
    logic w_busy;      // transaction outstanding toward moduleB
    logic w_rsp_seen;
    logic w_timeout;

    assign req_ready  = (r_state == ST_IDLE) && !rst;
    assign w_req_fire = req_valid && req_ready;
    assign w_busy     = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign w_rsp_seen = b_extra_out[c_rsp_valid_bit];

`ifdef B_PORT_PEER_TIMEOUT_EN
    b_port_timer #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_req_fire),
        .enable  (w_busy),
        .expired (w_timeout)
    );
    assign rsp_err = r_rsp_err;
`else
    assign w_timeout = 1'b0;
    assign rsp_err   = 1'b0;
`endif

    // Next-state logic. A response seen in the same cycle the timer expires
    // takes precedence over the timeout.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_req_fire) w_next_state = ST_ISSUE;
            ST_ISSUE,
            ST_WAIT: begin
                if (w_rsp_seen || w_timeout) w_next_state = ST_RESP;
                else                         w_next_state = ST_WAIT;
            end
            ST_RESP:  if (rsp_ready) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_data_to_b  <= '0;
            r_strobe     <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_status <= '0;
            r_rsp_err    <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            // Strobe is high for exactly the ISSUE cycle.
            r_strobe <= w_req_fire;
            if (w_req_fire) begin
                r_data_to_b <= req_data;
            end
            if (w_busy && w_rsp_seen) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_data   <= data_from_B;
                r_rsp_status <= b_extra_out;
                r_rsp_err    <= 1'b0;
            end else if (w_busy && w_timeout) begin
                r_rsp_valid  <= 1'b1;
                r_rsp_data   <= '0;
                r_rsp_status <= '0;
                r_rsp_err    <= 1'b1;
            end else if ((r_state == ST_RESP) && rsp_ready) begin
                r_rsp_valid  <= 1'b0;
            end
        end
    end

    always_comb begin
        b_extra_in               = '0;
        b_extra_in[c_strobe_bit] = r_strobe;
    end

    assign data_to_B  = r_data_to_b;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_status = r_rsp_status;

endmodule

`default_nettype wire

// File: tb/tb_b_port_peer.sv
// ============================================================================
// Module   : tb_b_port_peer
// Purpose  : Self-checking bench for b_port_peer. A transaction-level model
//            (outstanding flag, age in cycles, held response) predicts every
//            output each cycle; directed sequences pin exact latencies and
//            values, then randomized traffic exercises the rest.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_b_port_peer;

    localparam int DW  = 32;
    localparam int EW  = 4;
    localparam int TMO = 16;
`ifdef B_PORT_PEER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [DW-1:0] req_data = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [EW-1:0] rsp_status;
    logic          rsp_err;
    logic [DW-1:0] data_to_B;
    logic [DW-1:0] data_from_B = '0;
    logic [EW-1:0] b_extra_in;
    logic [EW-1:0] b_extra_out = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    b_port_peer #(
        .DATA_TO_B_BITWIDTH   (DW),
        .DATA_FROM_B_BITWIDTH (DW),
        .B_EXTRA_IN_BITWIDTH  (EW),
        .B_EXTRA_OUT_BITWIDTH (EW),
        .TIMEOUT_CYCLES       (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_data    (req_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_status  (rsp_status),
        .rsp_err     (rsp_err),
        .data_to_B   (data_to_B),
        .data_from_B (data_from_B),
        .b_extra_in  (b_extra_in),
        .b_extra_out (b_extra_out)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          m_busy, m_held, m_strobe, m_rv, m_re;
    int          m_age;
    logic [DW-1:0] m_dtb, m_rd;
    logic [EW-1:0] m_rs;

    initial begin
        m_busy = 0; m_held = 0; m_strobe = 0; m_rv = 0; m_re = 0;
        m_age = 0; m_dtb = '0; m_rd = '0; m_rs = '0;
    end

    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 0; m_held <= 0; m_strobe <= 0; m_rv <= 0; m_re <= 0;
            m_age <= 0; m_dtb <= '0; m_rd <= '0; m_rs <= '0;
        end else begin
            m_strobe <= 0;
            if (!m_busy && !m_held) begin
                if (req_valid) begin
                    m_dtb <= req_data; m_busy <= 1; m_age <= 1; m_strobe <= 1;
                end
            end else if (m_busy) begin
                if (b_extra_out[0]) begin
                    m_busy <= 0; m_held <= 1; m_rv <= 1; m_re <= 0;
                    m_rd <= data_from_B; m_rs <= b_extra_out;
                end else if (TMO_EN && m_age >= TMO) begin
                    m_busy <= 0; m_held <= 1; m_rv <= 1; m_re <= 1;
                    m_rd <= '0; m_rs <= '0;
                end else begin
                    m_age <= m_age + 1;
                end
            end else if (rsp_ready) begin
                m_held <= 0; m_rv <= 0;
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        chk("m_req_ready", 64'(req_ready), 64'(!m_busy && !m_held && !rst));
        chk("m_rsp_valid", 64'(rsp_valid), 64'(m_rv));
        chk("m_data_to_B", 64'(data_to_B), 64'(m_dtb));
        chk("m_b_extra_in", 64'(b_extra_in), 64'({3'b000, m_strobe}));
        chk("m_rsp_err", 64'(rsp_err), 64'(m_re));
        if (m_rv || rst) begin
            chk("m_rsp_data", 64'(rsp_data), 64'(m_rd));
            chk("m_rsp_status", 64'(rsp_status), 64'(m_rs));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int waited;
        logic [DW-1:0] held_d;
        repeat (3) tick();
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_b_extra_in", 64'(b_extra_in), 64'(0));
        chk("reset_req_ready", 64'(req_ready), 64'(0));
        rst = 1'b0;
        #1 chk("post_reset_req_ready", 64'(req_ready), 64'(1));
        tick();

        // Basic transaction, response three cycles after the handshake.
        req_valid = 1'b1; req_data = 32'hDEADBEEF;          // cycle N
        tick();                                             // N+1
        req_valid = 1'b0;
        chk("basic_data_to_B", 64'(data_to_B), 64'h0DEADBEEF);
        chk("basic_strobe_on", 64'(b_extra_in), 64'h1);
        tick();                                             // N+2
        chk("basic_strobe_off", 64'(b_extra_in), 64'h0);
        tick();                                             // N+3
        b_extra_out = 4'h1; data_from_B = 32'h12345678;
        chk("basic_no_rsp_yet", 64'(rsp_valid), 64'(0));
        tick();                                             // N+4
        b_extra_out = 4'h0;
        chk("basic_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("basic_rsp_data", 64'(rsp_data), 64'h12345678);
        chk("basic_rsp_status", 64'(rsp_status), 64'h1);

        // Backpressure: response held, new B activity ignored.
        for (int i = 0; i < 5; i++) begin
            data_from_B = $urandom; b_extra_out = 4'($urandom) | 4'h1;
            tick();
            chk("bp_rsp_data", 64'(rsp_data), 64'h12345678);
            chk("bp_req_ready", 64'(req_ready), 64'(0));
        end
        b_extra_out = 4'h0; rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_release_valid", 64'(rsp_valid), 64'(0));
        chk("bp_release_ready", 64'(req_ready), 64'(1));

        // Response already present during ISSUE.
        req_valid = 1'b1; req_data = 32'h0BADF00D;
        tick();
        req_valid = 1'b0; b_extra_out = 4'h3; data_from_B = 32'hCAFEF00D;
        tick();
        b_extra_out = 4'h0;
        chk("fast_rsp_valid", 64'(rsp_valid), 64'(1));
        chk("fast_rsp_data", 64'(rsp_data), 64'hCAFEF00D);
        chk("fast_rsp_status", 64'(rsp_status), 64'h3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // No response from B.
        req_valid = 1'b1; req_data = 32'h55AA55AA;
        tick();
        req_valid = 1'b0;
        waited = 0;
        while (!rsp_valid && waited < 120) begin
            tick();
            waited++;
        end
        if (TMO_EN) begin
            chk("tmo_latency", 64'(waited), 64'(TMO));
            chk("tmo_err", 64'(rsp_err), 64'(1));
            chk("tmo_data", 64'(rsp_data), 64'(0));
            b_extra_out = 4'h1; data_from_B = 32'hAAAA5555;
            repeat (3) tick();
            chk("tmo_late_ignored", 64'(rsp_data), 64'(0));
            b_extra_out = 4'h0; rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end else begin
            chk("notmo_still_waiting", 64'(rsp_valid), 64'(0));
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end

        // Reset while waiting for B.
        req_valid = 1'b1; req_data = 32'h13579BDF;
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_wait_data_to_B", 64'(data_to_B), 64'(0));
        chk("rst_wait_req_ready", 64'(req_ready), 64'(0));
        rst = 1'b0; b_extra_out = 4'h1; data_from_B = 32'hFFFF0000;
        #1 chk("rst_wait_ready_back", 64'(req_ready), 64'(1));
        held_d = 32'h0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_wait_no_stale", 64'(rsp_valid), 64'(held_d[0]));
        end
        b_extra_out = 4'h0;

        // Randomized traffic, checked by the model.
        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            req_valid   = 1'($urandom);
            req_data    = $urandom;
            rsp_ready   = 1'($urandom);
            data_from_B = $urandom;
            b_extra_out = {3'($urandom), 1'($urandom_range(0, 7) == 0)};
            tick();
        end
        rst = 1'b0; req_valid = 1'b0; b_extra_out = 4'h0; rsp_ready = 1'b1;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
